// File: rtl/serial_in_parallel_out.sv
// LSB-first serial-to-parallel deserializer with a selectable 24-bit or DATA_WIDTH word length.
// Completed words sit in a registered output stage with valid/ready handshake and a sticky overflow flag.
module serial_in_parallel_out #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  data_in,
    input  logic                  valid_in,
    input  logic                  mode_24,
    input  logic                  clear,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid_out,
    output logic                  busy,
    output logic [5:0]            bit_count,
    output logic                  overflow
);

    localparam logic [5:0] LAST_FULL = 6'(DATA_WIDTH - 1);
    localparam logic [5:0] LAST_24   = 6'd23;

    typedef enum logic {
        IDLE,
        COLLECT
    } state_t;

    state_t                state;
    state_t                state_next;
    logic                  len_24;
    logic                  len_24_next;
    logic [DATA_WIDTH-1:0] assembly;
    logic [DATA_WIDTH-1:0] assembly_next;
    logic [DATA_WIDTH-1:0] with_bit;
    logic [DATA_WIDTH-1:0] data_next;
    logic [5:0]            count_next;
    logic [5:0]            last_index;
    logic                  use_24;
    logic                  complete;
    logic                  valid_next;
    logic                  overflow_next;

    always_comb begin
        state_next    = state;
        len_24_next   = len_24;
        assembly_next = assembly;
        count_next    = bit_count;
        data_next     = data_out;
        valid_next    = valid_out;
        overflow_next = overflow;

        // The length is taken live from mode_24 on the first bit, and from the latch afterwards.
        use_24     = (state == IDLE) ? mode_24 : len_24;
        last_index = use_24 ? LAST_24 : LAST_FULL;
        complete   = valid_in && (bit_count == last_index);

        with_bit = assembly;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            if (bit_count == 6'(i)) begin
                with_bit[i] = data_in;
            end
        end

        if (valid_out && out_ready) begin
            valid_next = 1'b0;
        end

        if (clear) begin
            state_next    = IDLE;
            len_24_next   = 1'b0;
            assembly_next = '0;
            count_next    = 6'd0;
            data_next     = '0;
            valid_next    = 1'b0;
            overflow_next = 1'b0;
        end else if (valid_in) begin
            if (complete) begin
                // A word completing against an unconsumed one replaces it and flags the loss.
                data_next     = with_bit;
                valid_next    = 1'b1;
                assembly_next = '0;
                count_next    = 6'd0;
                state_next    = IDLE;
                if (valid_out && !out_ready) begin
                    overflow_next = 1'b1;
                end
            end else begin
                assembly_next = with_bit;
                count_next    = bit_count + 6'd1;
                state_next    = COLLECT;
                len_24_next   = use_24;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            len_24    <= 1'b0;
            assembly  <= '0;
            bit_count <= 6'd0;
            data_out  <= '0;
            valid_out <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            state     <= state_next;
            len_24    <= len_24_next;
            assembly  <= assembly_next;
            bit_count <= count_next;
            data_out  <= data_next;
            valid_out <= valid_next;
            overflow  <= overflow_next;
        end
    end

    assign busy = (bit_count != 6'd0);

endmodule

// File: tb/tb_serial_in_parallel_out.sv
// Self-checking bench for serial_in_parallel_out: directed scenarios plus random traffic
// compared every cycle against a queue-based reference model.
module tb_serial_in_parallel_out;

    localparam int DW = 32;

    logic          clk;
    logic          reset;
    logic          data_in;
    logic          valid_in;
    logic          mode_24;
    logic          clear;
    logic          out_ready;
    logic [DW-1:0] data_out;
    logic          valid_out;
    logic          busy;
    logic [5:0]    bit_count;
    logic          overflow;

    int compared;
    int mismatched;

    bit            q[$];
    int            m_len;
    logic [DW-1:0] m_data;
    bit            m_valid;
    bit            m_ovf;

    serial_in_parallel_out #(.DATA_WIDTH(DW)) dut (
        .clk       (clk),
        .reset     (reset),
        .data_in   (data_in),
        .valid_in  (valid_in),
        .mode_24   (mode_24),
        .clear     (clear),
        .out_ready (out_ready),
        .data_out  (data_out),
        .valid_out (valid_out),
        .busy      (busy),
        .bit_count (bit_count),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        if (obs !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        q.delete();
        m_len   = DW;
        m_data  = '0;
        m_valid = 1'b0;
        m_ovf   = 1'b0;
    endtask

    // Reference behaviour: a word is the list of accepted bits, weighted by arrival position.
    task automatic modelStep();
        bit            old_valid;
        logic [63:0]   w;
        old_valid = m_valid;
        if (clear) begin
            modelReset();
        end else begin
            if (old_valid && out_ready) m_valid = 1'b0;
            if (valid_in) begin
                if (q.size() == 0) m_len = mode_24 ? 24 : DW;
                q.push_back(data_in);
                if (q.size() == m_len) begin
                    w = 64'd0;
                    for (int k = 0; k < q.size(); k++) begin
                        if (q[k]) w = w + (64'd1 << k);
                    end
                    if (old_valid && !out_ready) m_ovf = 1'b1;
                    m_data  = w[DW-1:0];
                    m_valid = 1'b1;
                    q.delete();
                end
            end
        end
    endtask

    task automatic compareAll();
        checkOutput("data_out", 64'(data_out), 64'(m_data));
        checkOutput("valid_out", 64'(valid_out), 64'(m_valid));
        checkOutput("bit_count", 64'(bit_count), 64'(q.size()));
        checkOutput("busy", 64'(busy), 64'(q.size() != 0));
        checkOutput("overflow", 64'(overflow), 64'(m_ovf));
    endtask

    task automatic applyStimulus(input logic d, input logic v, input logic m,
                                 input logic c, input logic rdy);
        data_in   = d;
        valid_in  = v;
        mode_24   = m;
        clear     = c;
        out_ready = rdy;
        @(posedge clk);
        modelStep();
        @(negedge clk);
        compareAll();
    endtask

    task automatic sendWord(input logic [DW-1:0] w, input int len, input logic m, input logic rdy);
        for (int i = 0; i < len; i++) begin
            applyStimulus(w[i], 1'b1, (i == 0) ? m : 1'b0, 1'b0, rdy);
        end
    endtask

    initial begin
        logic [DW-1:0] w;
        int            k;
        int            cyc;

        compared   = 0;
        mismatched = 0;
        reset      = 1'b0;
        data_in    = 1'b0;
        valid_in   = 1'b0;
        mode_24    = 1'b0;
        clear      = 1'b0;
        out_ready  = 1'b0;
        modelReset();

        repeat (3) @(negedge clk);
        checkOutput("reset data_out", 64'(data_out), 64'd0);
        checkOutput("reset valid_out", 64'(valid_out), 64'd0);
        checkOutput("reset bit_count", 64'(bit_count), 64'd0);
        checkOutput("reset busy", 64'(busy), 64'd0);
        reset = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        // 32-bit word, continuous bits
        sendWord(32'hA5C3_0F81, 32, 1'b0, 1'b1);
        checkOutput("b2b data", 64'(data_out), 64'hA5C3_0F81);
        checkOutput("b2b valid", 64'(valid_out), 64'd1);
        checkOutput("b2b count", 64'(bit_count), 64'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("b2b valid drop", 64'(valid_out), 64'd0);

        // 24-bit word with gaps and mode_24 toggling mid-word
        w   = 32'h0012_3456;
        k   = 0;
        cyc = 0;
        while (k < 24) begin
            if (cyc % 3 == 2) begin
                applyStimulus(1'b0, 1'b0, (k <= 5), 1'b0, 1'b1);
            end else begin
                applyStimulus(w[k], 1'b1, (k <= 5), 1'b0, 1'b1);
                k++;
                if (k < 24) checkOutput("m24 busy", 64'(busy), 64'd1);
            end
            cyc++;
        end
        checkOutput("m24 data", 64'(data_out), 64'h0012_3456);
        checkOutput("m24 valid", 64'(valid_out), 64'd1);

        // Backpressure and overwrite
        sendWord(32'h1111_1111, 32, 1'b0, 1'b0);
        sendWord(32'h2222_2222, 32, 1'b0, 1'b0);
        checkOutput("ovw data", 64'(data_out), 64'h2222_2222);
        checkOutput("ovw valid", 64'(valid_out), 64'd1);
        checkOutput("ovw overflow", 64'(overflow), 64'd1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("ovw valid drop", 64'(valid_out), 64'd0);
        checkOutput("ovw sticky", 64'(overflow), 64'd1);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        checkOutput("clear overflow", 64'(overflow), 64'd0);
        checkOutput("clear drops bit", 64'(bit_count), 64'd0);

        // Simultaneous accept and complete
        sendWord(32'h1357_9BDF, 32, 1'b0, 1'b0);
        w = 32'h2468_ACE0;
        for (int i = 0; i < 32; i++) begin
            applyStimulus(w[i], 1'b1, 1'b0, 1'b0, (i == 31));
        end
        checkOutput("sim valid", 64'(valid_out), 64'd1);
        checkOutput("sim data", 64'(data_out), 64'h2468_ACE0);
        checkOutput("sim overflow", 64'(overflow), 64'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        // Flush mid-word, then a clean word
        for (int i = 0; i < 13; i++) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        checkOutput("flush count", 64'(bit_count), 64'd0);
        checkOutput("flush busy", 64'(busy), 64'd0);
        sendWord(32'h0000_F00D, 32, 1'b0, 1'b1);
        checkOutput("flush clean word", 64'(data_out), 64'h0000_F00D);

        // Asynchronous reset mid-word
        sendWord(32'h0BAD_BEEF, 32, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        #2 reset = 1'b0;
        #1;
        checkOutput("areset data_out", 64'(data_out), 64'd0);
        checkOutput("areset valid_out", 64'(valid_out), 64'd0);
        checkOutput("areset busy", 64'(busy), 64'd0);
        checkOutput("areset bit_count", 64'(bit_count), 64'd0);
        checkOutput("areset overflow", 64'(overflow), 64'd0);
        modelReset();
        @(negedge clk);
        reset = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Random traffic against the model
        for (int n = 0; n < 4000; n++) begin
            applyStimulus(1'($urandom_range(0, 1)),
                          ($urandom_range(0, 9) < 7),
                          1'($urandom_range(0, 1)),
                          ($urandom_range(0, 99) == 0),
                          1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/serial_in_parallel_out.md
# serial_in_parallel_out

Receive-side deserializer for the Wi-Fi PHY bit path: collects an LSB-first serial bitstream, qualified per bit by `valid_in`, into 32-bit or 24-bit words. It then presents each word on a registered parallel output with a valid/ready handshake. It sits between the PHY receive chain and the word-wide memory/FIFO write port. It is the mirror of the PHY transmit serializer: bit index k of the word is the k-th accepted bit.

## Interface
- `DATA_WIDTH`, 32, parallel word width; legal range 24..63.
- `clk`  in  1  clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `data_in`  in  1  serial data bit, sampled when `valid_in`=1.
- `valid_in`  in  1  qualifies `data_in` for the current cycle.
- `mode_24`  in  1  word length select: 0 = DATA_WIDTH bits, 1 = 24 bits. Sampled only on the first bit of a word.
- `clear`  in  1  synchronous flush of all state.
- `out_ready`  in  1  consumer accepts `data_out` when `valid_out`=1.
- `data_out`  out  DATA_WIDTH  assembled word, held until accepted.
- `valid_out`  out  1  `data_out` holds an unconsumed word.
- `busy`  out  1  a word is partially assembled (bit count ≠ 0).
- `bit_count`  out  6  number of bits accepted into the current word.
- `overflow`  out  1  sticky: a completed word overwrote an unconsumed word.

## Operation
- **States.**
  - IDLE: count=0, no length latched.
  - COLLECT: 0 < count < length.
  - A word completes on the cycle its last bit is accepted, and the block returns to IDLE in the same edge.
- **Bit acceptance.** On a cycle with `valid_in`=1:
  - The shift register writes `data_in` at index `bit_count`.
  - `bit_count` increments.
  - Cycles with `valid_in`=0 hold all assembly state; gaps of any length are legal.
- **Length latch.**
  - `mode_24` is latched on the accepted bit where `bit_count`=0. Length = 24 if latched 1, else DATA_WIDTH.
  - Changes to `mode_24` mid-word have no effect.
- **Completion.** On acceptance of the bit where `bit_count` = length-1:
  - The full word, with this bit included, is written to the `data_out` register.
  - In 24-bit mode, bits [DATA_WIDTH-1:24] are 0.
  - `valid_out` is set and `bit_count` returns to 0.
  - The assembly register is cleared, so the next word starts without stale bits.
- **Output handshake.** The word transfers on any cycle with `valid_out`=1 and `out_ready`=1. `valid_out` then clears next edge unless a new word completes in the same cycle.
- **Overwrite.** A word completes while `valid_out`=1 and `out_ready`=0:
  - The new word overwrites `data_out`.
  - `valid_out` stays 1.
  - `overflow` sets and stays set until `clear` or reset.
- **Simultaneous accept and complete.** Completion with `valid_out`=1 and `out_ready`=1:
  - The old word is consumed and the new word is loaded.
  - `valid_out` stays 1; there is no overflow.
- **`clear`.** Highest priority after reset.
  - Sets `bit_count`, assembly register, `data_out`, `valid_out` and `overflow` to 0. The latched length is discarded.
  - A `valid_in` bit in the same cycle is dropped.
- **Reset (asynchronous, mid-word included).** Every output is 0: `data_out`=0, `valid_out`=0, `busy`=0, `bit_count`=0, `overflow`=0. A partial word is discarded.

## Timing
- **Latency.** Last bit accepted at edge N → `data_out`/`valid_out` valid after edge N, i.e. visible in cycle N+1.
- **Throughput.** Back-to-back bits with no idle cycle between words are supported. The first bit of word k+1 is accepted in cycle N+1.
- **Status outputs.** `busy` = (`bit_count` ≠ 0), combinational from the register. `bit_count` is registered.
- **Output stability.** `data_out` changes only on completion, `clear` or reset, and never while waiting for `out_ready` unless an overwrite occurs.
- **Valid/ready rules.** `out_ready` may be high with `valid_out`=0; this has no effect. `valid_out` does not depend combinationally on `out_ready`.

## Test plan
- **32-bit word, back-to-back.** Serialize 0xA5C3_0F81 LSB-first, `mode_24`=0, `valid_in` continuous, `out_ready`=1 → `valid_out` is 1 for exactly one cycle, the cycle after bit 31, with `data_out`=0xA5C3_0F81. `bit_count` reads 0 in that cycle.
- **24-bit mode with gaps.** Send 0x12_3456 with `mode_24`=1 on bit 0, toggled to 0 after bit 5, `valid_in` low every third cycle → `data_out`=0x0012_3456 after 24 accepted bits. `busy` is 1 for the whole word.
- **Backpressure and overwrite.** Hold `out_ready`=0 and send 0x1111_1111 then 0x2222_2222 → after word 2, `data_out`=0x2222_2222, `valid_out`=1, `overflow`=1. Then raise `out_ready` → `valid_out` drops next cycle and `overflow` stays 1.
- **Simultaneous accept and complete.** Raise `out_ready` in the same cycle word 2's last bit is accepted → `valid_out` stays 1, `data_out`=word 2, `overflow`=0.
- **Flush and reset mid-word.** After 13 bits, pulse `clear` → `bit_count`=0, `busy`=0, and the next 32 bits form a clean word. Repeat with an asynchronous `reset` low mid-cycle → all outputs are 0 immediately.
